// File: rtl/ser_pkg.sv
// ser_pkg: shared state encoding and counter-width helper for the word serializer
package ser_pkg;
  typedef enum logic [0:0] {SER_IDLE, SER_SHIFT} ser_state_t;
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction
endpackage

// File: rtl/word_serializer.sv
// word_serializer: valid/ready word in, one bit per clock out with first/last strobes and a one-word holding buffer
module word_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  ser_state_t state;
  logic [WIDTH-1:0] shreg, hold;
  logic [CW-1:0] cnt;
  logic hold_full, accept;
  assign word_ready = !hold_full && !reset;
  assign accept     = word_valid && word_ready;
  assign ser_valid  = state == SER_SHIFT;
  assign ser_bit    = ser_valid && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
  assign ser_first  = ser_valid && cnt == '0;
  assign ser_last   = ser_valid && cnt == LAST;
  assign busy       = ser_valid || hold_full;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SER_IDLE;
      shreg     <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (state == SER_IDLE) begin
      if (accept) begin
        shreg <= word_in;
        cnt   <= '0;
        state <= SER_SHIFT;
      end
    end else if (cnt != LAST) begin
      shreg <= MSB_FIRST ? shreg << 1 : shreg >> 1;
      cnt   <= cnt + 1'b1;
      if (accept) begin
        hold      <= word_in;
        hold_full <= 1'b1;
      end
    end else if (hold_full) begin
      shreg     <= hold;
      hold_full <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      shreg <= word_in;
      cnt   <= '0;
    end else begin
      state <= SER_IDLE;
      cnt   <= '0;
    end
  end
endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: directed vector table plus hand sequences for MSB-first and LSB-first serializers
module tb_word_serializer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] word_in = '0, word2 = '0;
  logic word_valid = 1'b0, valid2 = 1'b0;
  logic word_ready, ser_bit, ser_valid, ser_first, ser_last, busy;
  logic ready2, bit2, sv2, first2, last2, busy2;
  int checks = 0, failures = 0;

  typedef struct packed {
    logic       rst;
    logic       vld;
    logic [7:0] w;
    logic [5:0] exp;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  word_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .ser_bit(ser_bit), .ser_valid(ser_valid),
    .ser_first(ser_first), .ser_last(ser_last), .busy(busy));

  word_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .reset(reset), .word_in(word2), .word_valid(valid2),
    .word_ready(ready2), .ser_bit(bit2), .ser_valid(sv2),
    .ser_first(first2), .ser_last(last2), .busy(busy2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic [7:0] w, input logic [5:0] e);
    vecs.push_back('{rst: r, vld: v, w: w, exp: e});
  endtask

  function automatic logic [5:0] outs();
    return {word_ready, ser_valid, ser_bit, ser_first, ser_last, busy};
  endfunction

  initial begin
    logic [7:0] pa, pf, pc;
    pa = 8'hA5;
    pf = 8'hF0;
    pc = 8'h3C;
    // expected vector: {word_ready, ser_valid, ser_bit, ser_first, ser_last, busy}
    add(1, 0, 8'h00, 6'b000000);
    add(1, 1, 8'h55, 6'b000000);
    add(0, 0, 8'h00, 6'b100000);
    add(0, 1, 8'hA5, 6'b100000);
    for (int i = 0; i < 8; i++) add(0, 0, 8'h00, {2'b11, pa[7-i], i == 0, i == 7, 1'b1});
    add(0, 0, 8'h00, 6'b100000);
    add(0, 1, 8'hFF, 6'b100000);
    add(0, 1, 8'h00, 6'b111101);
    for (int i = 1; i < 8; i++) add(0, 0, 8'h00, {3'b011, 1'b0, i == 7, 1'b1});
    for (int i = 0; i < 8; i++) add(0, 0, 8'h00, {3'b110, i == 0, i == 7, 1'b1});
    add(0, 1, 8'hF0, 6'b100000);
    for (int i = 0; i < 8; i++)
      add(0, i == 7, (i == 7) ? 8'h3C : 8'h00, {2'b11, pf[7-i], i == 0, i == 7, 1'b1});
    for (int i = 0; i < 8; i++) add(0, 0, 8'h00, {2'b11, pc[7-i], i == 0, i == 7, 1'b1});
    add(0, 0, 8'h00, 6'b100000);

    tick();
    foreach (vecs[k]) begin
      reset = vecs[k].rst;
      word_valid = vecs[k].vld;
      word_in = vecs[k].w;
      #1;
      chk($sformatf("row%0d", k), 32'(outs()), 32'(vecs[k].exp));
      tick();
    end
    word_valid = 1'b0;

    // LSB-first: 0x01 gives a 1 then seven 0s
    valid2 = 1'b1;
    word2 = 8'h01;
    #1;
    chk("lsb_ready", 32'(ready2), 32'd1);
    tick();
    valid2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("lsb_bit%0d", i), 32'({sv2, bit2, first2, last2}),
          32'({1'b1, i == 0, i == 0, i == 7}));
      tick();
    end
    chk("lsb_idle", 32'({sv2, busy2}), 32'd0);

    // reset mid-word with a held word discards both
    word_valid = 1'b1;
    word_in = 8'h12;
    tick();
    word_in = 8'h34;
    tick();
    word_valid = 1'b0;
    chk("hold_full_ready", 32'(word_ready), 32'd0);
    tick();
    tick();
    chk("cnt3_busy", 32'({ser_valid, busy, ser_first, ser_last}), 32'b1100);
    reset = 1'b1;
    #1;
    chk("rst_ready_low", 32'(word_ready), 32'd0);
    tick();
    chk("rst_outs", 32'({word_ready, ser_valid, busy, ser_bit}), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(word_ready), 32'd1);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("no_held_emit%0d", i), 32'({ser_valid, busy}), 32'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Parallel-to-serial front end that feeds the even/odd parity detector's serial input.
- Accepts WIDTH-bit words on a valid/ready handshake and emits them one bit per clock.
- Provides first/last framing strobes.
- A one-entry holding buffer allows back-to-back words to stream with no idle bit between them.

Parameters:
- WIDTH, 8: bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is emitted first; 0 = bit 0 is emitted first.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- word_in  input  WIDTH  parallel word to serialize.
- word_valid  input  1  word_in is valid this cycle.
- word_ready  output  1  block can accept word_in this cycle.
- ser_bit  output  1  serial data; connects to the detector's serial input.
- ser_valid  output  1  ser_bit carries a word bit this cycle.
- ser_first  output  1  ser_bit is the first bit of a word.
- ser_last  output  1  ser_bit is the last bit of a word.
- busy  output  1  a word is shifting or one is held.

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high (reset).
- Registers:
  - state: IDLE or SHIFT.
  - shreg: WIDTH bits.
  - cnt: $clog2(WIDTH) bits.
  - hold: WIDTH bits.
  - hold_full: 1 bit.
- Reset (reset=1 at a rising edge):
  - state=IDLE, shreg=0, cnt=0, hold=0, hold_full=0.
  - Outputs: ser_bit=0, ser_valid=0, ser_first=0, ser_last=0, busy=0.
  - word_ready is forced to 0 while reset is high; any word offered then is ignored.
  - A reset mid-word discards both the word being shifted and the held word, with no partial output after the reset edge.
- Handshake:
  - accept = word_valid & word_ready.
  - word_ready = !hold_full & !reset.
  - word_in is sampled only on accept. While word_ready=0, the offered word is not consumed, and is never consumed twice.
- Output decode (combinational from registers):
  - ser_valid = (state==SHIFT).
  - ser_bit = ser_valid ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : 0.
  - ser_first = ser_valid & (cnt==0).
  - ser_last = ser_valid & (cnt==WIDTH-1).
  - busy = ser_valid | hold_full.
- IDLE:
  - hold_full is always 0.
  - On accept: shreg<=word_in, cnt<=0, state<=SHIFT. The first bit appears the cycle after accept (latency 1).
- SHIFT, cnt<WIDTH-1:
  - shreg shifts toward the output end (left if MSB_FIRST, else right), zero-filling; cnt++.
  - On accept: hold<=word_in, hold_full<=1.
- SHIFT, cnt==WIDTH-1 (last bit):
  - If hold_full: shreg<=hold, hold_full<=0, cnt<=0, stay in SHIFT. word_ready stays 0 this cycle.
  - Else if accept: shreg<=word_in, cnt<=0, stay in SHIFT. No bubble.
  - Else: state<=IDLE, cnt<=0.
- Throughput: a continuous stream of accepts yields exactly WIDTH valid bits per word with no gaps.
- Downstream contract: ser_bit is 0 whenever ser_valid=0. Consumers that count bits must qualify ser_bit with ser_valid.

Decomposition:
- Shared package ser_pkg holds:
  - typedef enum logic [0:0] {SER_IDLE, SER_SHIFT} ser_state_t.
  - A function cnt_w(width) returning $clog2(width).
- No sub-module. The holding buffer and shift register are flat registers in the one module.

Test Plan:
All scenarios use WIDTH=8.
- MSB_FIRST=1, reset, then accept 0xA5 at cycle T -> cycles T+1..T+8: ser_bit 1,0,1,0,0,1,0,1; ser_first at T+1, ser_last at T+8; ser_valid=0 at T+9; busy=0 at T+9.
- MSB_FIRST=0, accept 0x01 -> ser_bit 1 then seven 0s; ser_last on the 8th bit.
- word_valid held high with 0xFF then 0x00 -> 16 consecutive ser_valid cycles, bits 8x1 then 8x0. word_ready=0 from the cycle after the second accept until the held word loads. 0x00 is emitted once only.
- Hold empty, 0x3C offered only in the cycle where ser_last=1 for 0xF0 -> accepted; the first bit of 0x3C appears the next cycle with no bubble.
- Reset asserted while cnt==3 and hold_full=1 -> next cycle ser_valid=0, busy=0, word_ready=0 while reset is high, then 1. The held word is never emitted.
- word_valid asserted during reset with 0x55 -> not accepted; after reset deasserts, ser_valid stays 0 until a new accept.
